solicitud_peatonal: RTL and testbench

SOLICITUD_PEATONAL -- requirements
Module: solicitud_peatonal

---
 rtl/semaforos_pkg.sv | 24 ++
 rtl/antirrebote.sv | 59 +++++
 rtl/solicitud_peatonal.sv | 104 ++++++++++
 tb/tb_solicitud_peatonal.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/semaforos_pkg.sv
// semaforos_pkg: shared light-state encoding used by the traffic-light
// controller and by the pedestrian request logic.
//   LUZ_W     - width of a light-state bus
//   ROJO      - 2'b00, red
//   AMARILLO  - 2'b01, amber
//   VERDE     - 2'b10, green
//   2'b11 is not a legal state and is deliberately treated as "not red".
package semaforos_pkg;

  localparam int unsigned LUZ_W = 2;

  typedef logic [LUZ_W-1:0] luz_t;

  localparam luz_t ROJO     = 2'b00;
  localparam luz_t AMARILLO = 2'b01;
  localparam luz_t VERDE    = 2'b10;

  // Only the exact ROJO code counts as red; the invalid code falls on the
  // "not red" side so a corrupted feedback never silently serves a request.
  function automatic logic es_rojo(input luz_t luz);
    return (luz == ROJO);
  endfunction

endpackage

// File: rtl/antirrebote.sv
// antirrebote: button conditioning for one pedestrian push-button.
//   2-flop synchronizer -> consecutive-cycle debounce -> rising-edge pulse.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-low
//   enb    - clock enable; all state holds while low
//   boton  - raw asynchronous, bouncing, active-high button
//   pulso  - high during the one enabled cycle after the debounced level
//            went 0->1 (combinational from registered state)
// Parameter:
//   DEB_CYCLES - consecutive enabled cycles the synchronized level must
//                disagree with the debounced level before it is accepted
//                (2..255)
module antirrebote #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enb,
  input  logic boton,
  output logic pulso
);

  localparam logic [7:0] CNT_MAX = 8'(DEB_CYCLES - 1);

  logic       sinc_1;
  logic       sinc_2;
  logic       nivel;
  logic       nivel_prev;
  logic [7:0] cuenta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sinc_1     <= 1'b0;
      sinc_2     <= 1'b0;
      nivel      <= 1'b0;
      nivel_prev <= 1'b0;
      cuenta     <= '0;
    end else if (enb) begin
      sinc_1     <= boton;
      sinc_2     <= sinc_1;
      nivel_prev <= nivel;
      // Any agreeing cycle restarts the count; the level flips on the
      // cycle that completes DEB_CYCLES consecutive disagreements.
      if (sinc_2 == nivel) begin
        cuenta <= '0;
      end else if (cuenta == CNT_MAX) begin
        nivel  <= sinc_2;
        cuenta <= '0;
      end else begin
        cuenta <= cuenta + 8'd1;
      end
    end
  end

  // Only presses matter; releases never produce a pulse.
  assign pulso = nivel & ~nivel_prev;

endmodule

// File: rtl/solicitud_peatonal.sv
// solicitud_peatonal: latches pedestrian crossing requests for two roads and
// clears them once the corresponding light has turned red.
// Ports:
//   clk                   - clock, rising edge
//   reset                 - asynchronous, active-low
//   enb                   - clock enable; state freezes, servido_x forced 0
//   boton_A / boton_B     - raw bouncing buttons, active-high
//   semaforo_A / _B       - current light state fed back from the controller
//   Apeatonal / Bpeatonal - registered pending request per road
//   servido_A / _B        - registered one-cycle pulse when a pending request
//                           is served (light became red)
// Parameter:
//   DEB_CYCLES            - debounce length, passed to both button channels
module solicitud_peatonal
  import semaforos_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic             boton_A,
  input  logic             boton_B,
  input  logic [LUZ_W-1:0] semaforo_A,
  input  logic [LUZ_W-1:0] semaforo_B,
  output logic             Apeatonal,
  output logic             Bpeatonal,
  output logic             servido_A,
  output logic             servido_B
);

  logic pulso_A;
  logic pulso_B;
  luz_t prev_A;
  luz_t prev_B;
  logic servir_A;
  logic servir_B;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_antirrebote_A (
    .clk   (clk),
    .reset (reset),
    .enb   (enb),
    .boton (boton_A),
    .pulso (pulso_A)
  );

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_antirrebote_B (
    .clk   (clk),
    .reset (reset),
    .enb   (enb),
    .boton (boton_B),
    .pulso (pulso_B)
  );

  // Serve on the transition into red, not on red itself.
  always_comb begin
    servir_A = !es_rojo(prev_A) && es_rojo(semaforo_A);
    servir_B = !es_rojo(prev_B) && es_rojo(semaforo_B);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_A    <= ROJO;
      Apeatonal <= 1'b0;
      servido_A <= 1'b0;
    end else if (enb) begin
      prev_A <= semaforo_A;
      // Clearing has priority over a press arriving in the same cycle.
      if (servir_A) begin
        Apeatonal <= 1'b0;
        servido_A <= Apeatonal;
      end else begin
        servido_A <= 1'b0;
        if (pulso_A && !es_rojo(semaforo_A)) begin
          Apeatonal <= 1'b1;
        end
      end
    end else begin
      servido_A <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_B    <= ROJO;
      Bpeatonal <= 1'b0;
      servido_B <= 1'b0;
    end else if (enb) begin
      prev_B <= semaforo_B;
      if (servir_B) begin
        Bpeatonal <= 1'b0;
        servido_B <= Bpeatonal;
      end else begin
        servido_B <= 1'b0;
        if (pulso_B && !es_rojo(semaforo_B)) begin
          Bpeatonal <= 1'b1;
        end
      end
    end else begin
      servido_B <= 1'b0;
    end
  end

endmodule

// File: tb/tb_solicitud_peatonal.sv
// Directed bench for solicitud_peatonal with DEB_CYCLES = 4.
module tb_solicitud_peatonal;
  import semaforos_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enb = 1'b0;
  logic       boton_A = 1'b0;
  logic       boton_B = 1'b0;
  logic [1:0] semaforo_A = ROJO;
  logic [1:0] semaforo_B = ROJO;
  logic       Apeatonal;
  logic       Bpeatonal;
  logic       servido_A;
  logic       servido_B;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  solicitud_peatonal #(.DEB_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enb        (enb),
    .boton_A    (boton_A),
    .boton_B    (boton_B),
    .semaforo_A (semaforo_A),
    .semaforo_B (semaforo_B),
    .Apeatonal  (Apeatonal),
    .Bpeatonal  (Bpeatonal),
    .servido_A  (servido_A),
    .servido_B  (servido_B)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle; inputs changed after this are
  // sampled at the next edge.
  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_Apeatonal", 32'(Apeatonal), 32'd0);
    check("rst_Bpeatonal", 32'(Bpeatonal), 32'd0);
    check("rst_servido_A", 32'(servido_A), 32'd0);
    check("rst_servido_B", 32'(servido_B), 32'd0);
    tick();
    reset = 1'b1;
    enb   = 1'b1;
    semaforo_A = VERDE;
    semaforo_B = VERDE;
    tick(3);

    // Clean press on A: first sampled at edge k, rises after edge k+6
    boton_A = 1'b1;
    tick(6);
    check("press_A_before", 32'(Apeatonal), 32'd0);
    tick();
    check("press_A_rise", 32'(Apeatonal), 32'd1);
    check("press_A_B_indep", 32'(Bpeatonal), 32'd0);
    boton_A = 1'b0;
    tick(8);
    check("press_A_holds", 32'(Apeatonal), 32'd1);

    // Repeat press while pending: still just pending
    boton_A = 1'b1;
    tick(8);
    boton_A = 1'b0;
    tick(8);
    check("repeat_A", 32'(Apeatonal), 32'd1);

    // Serve: VERDE -> AMARILLO -> ROJO
    semaforo_A = AMARILLO;
    tick();
    check("amarillo_pending", 32'(Apeatonal), 32'd1);
    check("amarillo_no_srv", 32'(servido_A), 32'd0);
    semaforo_A = ROJO;
    tick();
    check("serve_A_clear", 32'(Apeatonal), 32'd0);
    check("serve_A_pulse", 32'(servido_A), 32'd1);
    tick();
    check("serve_A_one_cyc", 32'(servido_A), 32'd0);

    // Bouncing button: toggles every 2 cycles for 20 cycles
    semaforo_A = VERDE;
    tick(2);
    for (int unsigned i = 0; i < 20; i++) begin
      boton_A = ((i / 2) % 2 == 0);
      tick();
    end
    boton_A = 1'b0;
    tick(10);
    check("bounce_A", 32'(Apeatonal), 32'd0);

    // Press accepted while already red: discarded, no pulse
    semaforo_A = ROJO;
    tick(2);
    boton_A = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      check("rojo_press_req", 32'(Apeatonal), 32'd0);
      check("rojo_press_srv", 32'(servido_A), 32'd0);
    end
    boton_A = 1'b0;
    tick(8);

    // Accepted press in the same cycle as AMARILLO -> ROJO
    semaforo_A = AMARILLO;
    tick(3);
    boton_A = 1'b1;
    tick(6);
    check("same_cyc_before", 32'(Apeatonal), 32'd0);
    semaforo_A = ROJO;
    tick();
    check("same_cyc_req", 32'(Apeatonal), 32'd0);
    check("same_cyc_srv", 32'(servido_A), 32'd0);
    boton_A = 1'b0;
    tick(8);

    // enb=0 for 10 cycles mid-debounce delays acceptance by 10 edges
    semaforo_A = VERDE;
    tick(2);
    boton_A = 1'b1;
    tick(2);
    enb = 1'b0;
    tick(10);
    check("enb_low_srv", 32'(servido_A), 32'd0);
    enb = 1'b1;
    tick(4);
    check("enb_delay_before", 32'(Apeatonal), 32'd0);
    tick();
    check("enb_delay_rise", 32'(Apeatonal), 32'd1);
    boton_A = 1'b0;

    // Invalid light code 2'b11 is not red, so no serve on entering it
    semaforo_A = 2'b11;
    tick(2);
    check("invalid_not_rojo", 32'(Apeatonal), 32'd1);
    semaforo_A = VERDE;

    // Pend B as well, then asynchronous reset with both pending
    boton_B = 1'b1;
    tick(7);
    check("press_B_rise", 32'(Bpeatonal), 32'd1);
    check("both_pending_A", 32'(Apeatonal), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_A", 32'(Apeatonal), 32'd0);
    check("async_rst_B", 32'(Bpeatonal), 32'd0);
    check("async_rst_srvA", 32'(servido_A), 32'd0);
    check("async_rst_srvB", 32'(servido_B), 32'd0);

    // Release reset with boton_B still held: accepted after normal debounce
    tick();
    reset = 1'b1;
    tick(6);
    check("rst_held_before", 32'(Bpeatonal), 32'd0);
    tick();
    check("rst_held_rise", 32'(Bpeatonal), 32'd1);
    check("rst_held_A", 32'(Apeatonal), 32'd0);

    // Serve B with A idle: pulse on B only
    boton_B = 1'b0;
    semaforo_B = ROJO;
    tick();
    check("serve_B_clear", 32'(Bpeatonal), 32'd0);
    check("serve_B_pulse", 32'(servido_B), 32'd1);
    check("serve_B_A_quiet", 32'(servido_A), 32'd0);
    tick();
    check("serve_B_one_cyc", 32'(servido_B), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
